// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-cycle boot, sequential fetch with stall and branch
// redirect, and a sticky halt once a HALT opcode retires into the instruction register.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [5:0]  branch_target,
  output logic [5:0]  imem_addr,
  output logic        imem_rd_en,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic        instr_valid,
  output logic [5:0]  pc_out,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [4:0] HALT_OP = 5'b11111;

  state_t     state_reg;
  logic [5:0] fetch_pc_reg;
  logic       rdata_valid_reg;
  logic [5:0] rdata_pc_reg;
  logic       halt_word;

  assign imem_addr = fetch_pc_reg;

  // A redirect must read even under stall so the pipeline refills without an extra bubble.
  assign imem_rd_en = rst_n &&
                      ((state_reg == BOOT) ||
                       ((state_reg == RUN) && (!stall || branch_taken)));

  assign halt_word = rdata_valid_reg && (imem_rdata[15:11] == HALT_OP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= BOOT;
      fetch_pc_reg    <= 6'd0;
      rdata_valid_reg <= 1'b0;
      rdata_pc_reg    <= 6'd0;
      instruction     <= 16'h0000;
      instr_valid     <= 1'b0;
      pc_out          <= 6'd0;
      halted          <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          fetch_pc_reg    <= 6'd1;
          rdata_valid_reg <= 1'b1;
          rdata_pc_reg    <= 6'd0;
          state_reg       <= RUN;
        end
        RUN: begin
          if (branch_taken) begin
            // Squash the word in flight; the decoder keeps its last word but marked dead.
            fetch_pc_reg    <= branch_target;
            rdata_valid_reg <= 1'b0;
            instr_valid     <= 1'b0;
          end else if (!stall) begin
            instruction     <= imem_rdata;
            pc_out          <= rdata_pc_reg;
            instr_valid     <= rdata_valid_reg;
            rdata_pc_reg    <= fetch_pc_reg;
            rdata_valid_reg <= 1'b1;
            fetch_pc_reg    <= fetch_pc_reg + 6'd1;
            if (halt_word) begin
              state_reg <= HALTED;
            end
          end
        end
        HALTED: begin
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          state_reg <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory plus a queue of expected
// fetch addresses that is drained whenever a fresh instruction becomes valid.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [5:0]  branch_target;
  logic [5:0]  imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [5:0]  pc_out;
  logic        halted;

  logic [15:0] mem [0:63];
  int          exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [5:0]  saved_addr;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory that holds its output while not enabled.
  initial imem_rdata = 16'h0000;
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_range(input int first, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back((first + i) % 64);
  endtask

  // One clock; compares against the scoreboard, or against the previous word when held.
  task automatic tick();
    logic        hold;
    logic [15:0] prev_instr;
    logic [5:0]  prev_pc;
    int          e;
    hold       = rst_n && stall && !branch_taken;
    prev_instr = instruction;
    prev_pc    = pc_out;
    @(posedge clk);
    #1;
    if (instr_valid) begin
      if (hold) begin
        check_eq("hold_instr", instruction, prev_instr);
        check_eq("hold_pc", {10'b0, pc_out}, {10'b0, prev_pc});
      end else if (exp_q.size() == 0) begin
        check_eq("extra_valid", {15'b0, instr_valid}, 16'h0000);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_pc", {10'b0, pc_out}, {10'b0, e[5:0]});
        check_eq("sb_instr", instruction, mem[e]);
        $display("word pc=%0d instr=%h", pc_out, instruction);
      end
    end
  endtask

  task automatic check_reset();
    check_eq("rst_instr", instruction, 16'h0000);
    check_eq("rst_valid", {15'b0, instr_valid}, 16'h0000);
    check_eq("rst_pc_out", {10'b0, pc_out}, 16'h0000);
    check_eq("rst_halted", {15'b0, halted}, 16'h0000);
    check_eq("rst_rd_en", {15'b0, imem_rd_en}, 16'h0000);
    check_eq("rst_addr", {10'b0, imem_addr}, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 6'd0;
    tick();
    tick();
    check_reset();

    // Boot and stream from address 0.
    rst_n = 1'b1;
    push_range(0, 6);
    repeat (7) tick();

    // Stall while mem[5] is presented.
    stall = 1'b1;
    #1;
    check_eq("stall_rd_en", {15'b0, imem_rd_en}, 16'h0000);
    saved_addr = imem_addr;
    repeat (3) begin
      tick();
      check_eq("stall_addr", {10'b0, imem_addr}, {10'b0, saved_addr});
      check_eq("stall_rd_en", {15'b0, imem_rd_en}, 16'h0000);
    end
    stall = 1'b0;
    push_range(6, 5);
    repeat (5) tick();

    // Branch to 40 while pc_out is 10: two bubbles.
    branch_taken = 1'b1; branch_target = 6'd40;
    #1;
    check_eq("br_rd_en", {15'b0, imem_rd_en}, 16'h0001);
    push_range(40, 2);
    tick();
    check_eq("br_bubble1", {15'b0, instr_valid}, 16'h0000);
    check_eq("br_pc_held", {10'b0, pc_out}, 16'd10);
    branch_taken = 1'b0;
    tick();
    check_eq("br_bubble2", {15'b0, instr_valid}, 16'h0000);
    tick();
    tick();

    // Branch under stall to 60, then wrap past 63.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 6'd60;
    push_range(60, 6);
    tick();
    check_eq("brst_bubble", {15'b0, instr_valid}, 16'h0000);
    stall = 1'b0; branch_taken = 1'b0;
    repeat (7) tick();

    // Branch on the same edge a HALT word would load: no halt.
    mem[3] = 16'hF800;
    branch_taken = 1'b1; branch_target = 6'd2;
    push_range(2, 1);
    tick();
    branch_taken = 1'b0;
    tick();
    tick();
    branch_taken = 1'b1; branch_target = 6'd8;
    push_range(8, 1);
    tick();
    check_eq("prio_valid", {15'b0, instr_valid}, 16'h0000);
    check_eq("prio_halted", {15'b0, halted}, 16'h0000);
    branch_taken = 1'b0;
    tick();
    tick();
    check_eq("prio_no_halt", {15'b0, halted}, 16'h0000);
    check_eq("prio_rd_en", {15'b0, imem_rd_en}, 16'h0001);

    // HALT retires at pc 3.
    branch_taken = 1'b1; branch_target = 6'd2;
    push_range(2, 2);
    tick();
    branch_taken = 1'b0;
    tick();
    tick();
    tick();
    check_eq("halt_word_valid", {15'b0, instr_valid}, 16'h0001);
    check_eq("halt_not_yet", {15'b0, halted}, 16'h0000);
    tick();
    check_eq("halt_valid", {15'b0, instr_valid}, 16'h0000);
    check_eq("halt_flag", {15'b0, halted}, 16'h0001);
    check_eq("halt_rd_en", {15'b0, imem_rd_en}, 16'h0000);
    branch_taken = 1'b1; branch_target = 6'd20;
    #1;
    check_eq("halt_br_rd_en", {15'b0, imem_rd_en}, 16'h0000);
    tick();
    check_eq("halt_br_flag", {15'b0, halted}, 16'h0001);
    check_eq("halt_br_valid", {15'b0, instr_valid}, 16'h0000);
    check_eq("halt_br_pc", {10'b0, pc_out}, 16'd3);
    branch_taken = 1'b0;
    tick();
    check_eq("halt_stays", {15'b0, halted}, 16'h0001);

    // Reset out of HALTED and restart.
    rst_n = 1'b0;
    tick();
    check_reset();
    mem[3] = 16'h0103;
    rst_n = 1'b1;
    push_range(0, 4);
    repeat (5) tick();

    // Reset in the middle of a redirect.
    branch_taken = 1'b1; branch_target = 6'd30;
    tick();
    branch_taken = 1'b0;
    rst_n = 1'b0;
    tick();
    check_reset();
    rst_n = 1'b1;
    push_range(0, 2);
    repeat (3) tick();

    check_eq("sb_drain", 16'(exp_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low.
REQ-002 Port: clk, input, 1, the only clock; every register updates on its rising edge.
REQ-003 Port: rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port: stall, input, 1, freezes fetch while high.
REQ-005 Port: branch_taken, input, 1, redirects fetch to branch_target.
REQ-006 Port: branch_target, input, 6, redirect address.
REQ-007 Port: imem_addr, output, 6, instruction memory read address (combinational from fetch_pc).
REQ-008 Port: imem_rd_en, output, 1, instruction memory read enable.
REQ-009 Port: imem_rdata, input, 16, memory read data, valid one cycle after a read; memory holds it while imem_rd_en is low.
REQ-010 Port: instruction, output, 16, instruction register feeding the decoder.
REQ-011 Port: instr_valid, output, 1, instruction holds a live instruction.
REQ-012 Port: pc_out, output, 6, address of the word in instruction.
REQ-013 Port: halted, output, 1, HALT has retired and fetch has stopped.

Function
REQ-014 Internal registers SHALL be: fetch_pc[5:0], rdata_valid, rdata_pc[5:0], and state {BOOT, RUN, HALTED}.
REQ-015 imem_addr SHALL equal fetch_pc.
REQ-016 imem_rd_en SHALL be 1 only when rst_n=1, state is BOOT or RUN, and stall=0 (or branch_taken=1 in RUN).
REQ-017 BOOT SHALL last one cycle: read address 0; next state RUN; fetch_pc becomes 1; rdata_valid becomes 1; rdata_pc becomes 0; branch_taken and stall are ignored.
REQ-018 On a RUN edge with stall=0 and branch_taken=0, the following updates SHALL occur together: instruction<=imem_rdata and pc_out<=rdata_pc; instr_valid<=rdata_valid; rdata_pc<=fetch_pc; rdata_valid<=1; fetch_pc<=fetch_pc+1 modulo 64 (63 wraps to 0).
REQ-019 A RUN edge with stall=1 and branch_taken=0 SHALL hold all registers and outputs unchanged.
REQ-020 On a RUN edge with branch_taken=1, the following SHALL occur regardless of stall: fetch_pc<=branch_target; rdata_valid<=0; instr_valid<=0; instruction and pc_out are held.
REQ-021 After a branch, mem[branch_target] SHALL appear with instr_valid=1 exactly two edges later, absent stall, giving 2 bubbles.
REQ-022 HALT detection SHALL use opcode field [15:11]; HALT is 5'b11111.
REQ-023 When REQ-018 loads a valid word with opcode 11111: it is presented with instr_valid=1 for that cycle; state becomes HALTED.
REQ-024 In HALTED: at the next edge instr_valid<=0 and halted<=1; imem_rd_en=0; stall and branch_taken are ignored; only reset exits.
REQ-025 A branch_taken on the same edge as a HALT load SHALL take priority, and no halt occurs.
REQ-026 instr_valid SHALL never be 1 for a word fetched before a taken branch or before reset.

Reset
REQ-027 On an edge with rst_n=0, the registers SHALL take these values: state=BOOT; fetch_pc=0; rdata_valid=0; rdata_pc=0; instruction=16'h0000; instr_valid=0; pc_out=0; halted=0.
REQ-028 While rst_n=0, imem_rd_en SHALL be 0.
REQ-029 Reset SHALL take effect mid-operation from any state, including HALTED, with the same values as REQ-027.

Verification
REQ-030 Scenario: memory mem[i]=16'h0100+i; release reset, no stall -> edge 2 after release: instruction=16'h0100, pc_out=0, instr_valid=1; edge 3: 16'h0101, pc_out=1.
REQ-031 Scenario: stall high for 3 cycles mid-stream while instruction=mem[5] -> instruction, pc_out and fetch_pc are unchanged; imem_rd_en=0; after release, mem[6] appears next edge with no loss or duplication.
REQ-032 Scenario: branch_taken=1, target 6'd40, while pc_out=10 -> instr_valid=0 for 2 edges, then instruction=mem[40], pc_out=40; no mem[11] or mem[12] is ever valid.
REQ-033 Scenario: run from 60 without branch -> pc_out sequence 60, 61, 62, 63, 0, 1.
REQ-034 Scenario: mem[3]=16'hF800 (HALT) -> pc_out=3 is valid for one cycle; next edge halted=1, instr_valid=0, imem_rd_en=0; branch_taken then has no effect.
REQ-035 Scenario: rst_n=0 for one edge while HALTED or mid-branch -> all REQ-027 values; restart identical to REQ-030.
